fdiv_mul: RTL and testbench

FDIV_MUL -- requirements
Module: fdiv_mul

---
 rtl/fdiv_mul_if.sv | 21 ++
 rtl/fdiv_mul.sv | 167 ++++++++++++++++
 tb/tb_fdiv_mul.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fdiv_mul_if.sv
// Issue/result bundle for the fdiv_mul divider, including the side channel
// to the external reciprocal unit.
interface fdiv_mul_if;
    logic        valid_in;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] finv_x;
    logic [31:0] finv_s;
    logic        valid_out;
    logic [31:0] q;

    modport master (
        output valid_in, a, b, finv_s,
        input  finv_x, valid_out, q
    );

    modport slave (
        input  valid_in, a, b, finv_s,
        output finv_x, valid_out, q
    );
endinterface

// File: rtl/fdiv_mul.sv
// Single-precision divide as a * finv(b): 4-cycle fully pipelined multiplier
// with round-to-nearest-even, flush-to-zero and IEEE special handling.
module fdiv_mul (
    input  logic       clk,
    input  logic       rst_n,
    fdiv_mul_if.slave  bus
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_NAN  = 2'd1,
        CLS_INF  = 2'd2,
        CLS_ZERO = 2'd3
    } cls_t;

    // Special-case priority: NaN (incl. inf*0) > inf > flushed zero > normal.
    function automatic cls_t classify(input logic [31:0] x, input logic [31:0] y);
        logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
        x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        x_zero = (x[30:23] == 8'h00);
        y_zero = (y[30:23] == 8'h00);
        if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
            classify = CLS_NAN;
        end else if (x_inf || y_inf) begin
            classify = CLS_INF;
        end else if (x_zero || y_zero) begin
            classify = CLS_ZERO;
        end else begin
            classify = CLS_NORM;
        end
    endfunction

    logic [31:0]       a_d1_r, a_d2_r;
    logic              v_d1_r, v_d2_r;
    logic [31:0]       a_s2_r, r_s2_r;
    logic              v_s2_r;
    logic [47:0]       prod_r;
    logic signed [9:0] esum_r;
    logic              sign_r;
    cls_t              cls_r;
    logic              v_s3_r;
    logic [31:0]       q_r;
    logic              vout_r;

    logic [23:0]       ma_s, mr_s;
    logic signed [9:0] esum_s;
    logic [22:0]       mant_s;
    logic              guard_s, sticky_s, rnd_s;
    logic [23:0]       mant_rnd_s;
    logic signed [9:0] exp_s, exp_fin_s;
    logic [31:0]       res_s;

    assign bus.finv_x    = bus.b;
    assign bus.q         = q_r;
    assign bus.valid_out = vout_r;

    // Delay line holding a and valid until the matching reciprocal arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_d1_r <= 32'd0;
            a_d2_r <= 32'd0;
            v_d1_r <= 1'b0;
            v_d2_r <= 1'b0;
        end else begin
            a_d1_r <= bus.a;
            a_d2_r <= a_d1_r;
            v_d1_r <= bus.valid_in;
            v_d2_r <= v_d1_r;
        end
    end

    // Capture stage: reciprocal joins its own dividend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s2_r <= 32'd0;
            r_s2_r <= 32'd0;
            v_s2_r <= 1'b0;
        end else begin
            a_s2_r <= a_d2_r;
            r_s2_r <= bus.finv_s;
            v_s2_r <= v_d2_r;
        end
    end

    // Significands with hidden bit and biased exponent sum.
    always_comb begin
        ma_s   = {1'b1, a_s2_r[22:0]};
        mr_s   = {1'b1, r_s2_r[22:0]};
        esum_s = $signed({2'b00, a_s2_r[30:23]}) + $signed({2'b00, r_s2_r[30:23]}) - 10'sd127;
    end

    // Product stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r <= 48'd0;
            esum_r <= 10'sd0;
            sign_r <= 1'b0;
            cls_r  <= CLS_NORM;
            v_s3_r <= 1'b0;
        end else begin
            prod_r <= {24'd0, ma_s} * {24'd0, mr_s};
            esum_r <= esum_s;
            sign_r <= a_s2_r[31] ^ r_s2_r[31];
            cls_r  <= classify(a_s2_r, r_s2_r);
            v_s3_r <= v_s2_r;
        end
    end

    // Normalise, round to nearest even, then range-check the exponent.
    always_comb begin
        mant_s     = 23'd0;
        guard_s    = 1'b0;
        sticky_s   = 1'b0;
        exp_s      = esum_r;
        if (prod_r[47]) begin
            mant_s   = prod_r[46:24];
            guard_s  = prod_r[23];
            sticky_s = |prod_r[22:0];
            exp_s    = esum_r + 10'sd1;
        end else begin
            mant_s   = prod_r[45:23];
            guard_s  = prod_r[22];
            sticky_s = |prod_r[21:0];
            exp_s    = esum_r;
        end
        rnd_s      = guard_s & (sticky_s | mant_s[0]);
        mant_rnd_s = {1'b0, mant_s} + {23'd0, rnd_s};
        // A carry out leaves the fraction at zero, so only the exponent moves.
        exp_fin_s  = exp_s + (mant_rnd_s[23] ? 10'sd1 : 10'sd0);
        res_s      = 32'd0;
        case (cls_r)
            CLS_NAN:  res_s = QNAN;
            CLS_INF:  res_s = {sign_r, 8'hFF, 23'd0};
            CLS_ZERO: res_s = {sign_r, 31'd0};
            default: begin
                if (exp_fin_s >= 10'sd255) begin
                    res_s = {sign_r, 8'hFF, 23'd0};
                end else if (exp_fin_s <= 10'sd0) begin
                    res_s = {sign_r, 31'd0};
                end else begin
                    res_s = {sign_r, exp_fin_s[7:0], mant_rnd_s[22:0]};
                end
            end
        endcase
    end

    // Output stage: q only moves when a valid result lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r    <= 32'd0;
            vout_r <= 1'b0;
        end else begin
            vout_r <= v_s3_r;
            if (v_s3_r) begin
                q_r <= res_s;
            end else begin
                q_r <= q_r;
            end
        end
    end

endmodule

// File: tb/tb_fdiv_mul.sv
// Scoreboard bench for fdiv_mul: an external 2-stage finv stand-in returns
// chosen reciprocals, and a real-arithmetic model predicts each quotient.
module tb_fdiv_mul;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    fdiv_mul_if fi();

    fdiv_mul u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fi)
    );

    always #5 clk = ~clk;

    // finv stand-in: returns the vector value two edges after presentation.
    logic [31:0] r_drv = 32'd0;
    logic [31:0] f1 = 32'd0;
    logic [31:0] f2 = 32'd0;
    always @(posedge clk) begin
        f1 <= r_drv;
        f2 <= f1;
    end
    assign fi.finv_s = f2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    int          cyc_q[$];
    logic [31:0] last_q;
    bit          have_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact real product of the significands, then RNE at 24 bits.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        int  ex, ey, e, m;
        bit  xnan, ynan, xinf, yinf, xz, yz, sg;
        real p, s, fl;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        sg = x[31] ^ y[31];
        xnan = (ex == 255) && (x[22:0] != 23'd0);
        ynan = (ey == 255) && (y[22:0] != 23'd0);
        xinf = (ex == 255) && (x[22:0] == 23'd0);
        yinf = (ey == 255) && (y[22:0] == 23'd0);
        xz = (ex == 0);
        yz = (ey == 0);
        if (xnan || ynan || (xinf && yz) || (yinf && xz)) return 32'h7FC0_0000;
        if (xinf || yinf) return {sg, 8'hFF, 23'd0};
        if (xz || yz) return {sg, 31'd0};
        p = (1.0 + real'(x[22:0]) / 8388608.0) * (1.0 + real'(y[22:0]) / 8388608.0);
        e = ex + ey - 254;
        if (p >= 2.0) begin
            p = p / 2.0;
            e++;
        end
        s = p * 8388608.0;
        fl = $floor(s);
        if ((s - fl > 0.5) || ((s - fl == 0.5) && ($rtoi(fl) % 2 == 1))) fl = fl + 1.0;
        m = $rtoi(fl);
        if (m == 16777216) begin
            m = 8388608;
            e++;
        end
        e = e + 127;
        if (e >= 255) return {sg, 8'hFF, 23'd0};
        if (e <= 0) return {sg, 31'd0};
        return {sg, 8'(e), 23'(m - 8388608)};
    endfunction

    function automatic logic [31:0] mk(input int e);
        logic        s;
        logic [22:0] f;
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        return {s, 8'(e), f};
    endfunction

    function automatic logic [31:0] rnd_any();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0: v = {1'($urandom_range(0, 1)), 31'd0};
            1: v = {1'($urandom_range(0, 1)), 8'h00, 23'($urandom_range(1, 8388607))};
            2: v = {1'($urandom_range(0, 1)), 8'hFF, 23'd0};
            3: v = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 8388607))};
            default: v = mk($urandom_range(1, 254));
        endcase
        return v;
    endfunction

    // Monitor: pops the oldest expectation whenever a result is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fi.valid_out) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got valid_out=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    chk("q", fi.q, exp_q.pop_front());
                    chk("latency", 32'(cyc), 32'(cyc_q.pop_front() + 4));
                end
                last_q = fi.q;
                have_last = 1'b1;
            end else if (have_last) begin
                chk("q_hold", fi.q, last_q);
            end
        end
    end

    task automatic issue(input logic [31:0] av, input logic [31:0] rv, input logic [31:0] ev);
        logic [31:0] bv;
        @(negedge clk);
        bv = $urandom;
        fi.valid_in = 1'b1;
        fi.a = av;
        fi.b = bv;
        r_drv = rv;
        exp_q.push_back(ev);
        cyc_q.push_back(cyc + 1);
        #1;
        if (cyc % 16 == 0) chk("finv_x", fi.finv_x, bv);
    endtask

    task automatic idle();
        @(negedge clk);
        fi.valid_in = 1'b0;
        fi.a = $urandom;
        fi.b = $urandom;
        r_drv = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            idle();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] av, rv;
        int t, lo, hi, ea;
        fi.valid_in = 1'b0;
        fi.a = 32'd0;
        fi.b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid_out", {31'd0, fi.valid_out}, 32'd0);
        chk("reset_q", fi.q, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'h3F80_0000, 32'h3F00_0000, 32'h3F00_0000);
        idle();
        idle();
        idle();
        issue(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
        issue(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
        issue(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000);
        issue(32'h0000_0000, 32'hBF80_0000, 32'h8000_0000);
        issue(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
        issue(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000);
        drain();

        for (int i = 0; i < 1000; i++) begin
            if (i == 500) idle();
            av = mk($urandom_range(1, 254));
            rv = mk($urandom_range(1, 254));
            issue(av, rv, ref_mul(av, rv));
        end

        // Exponent sweeps around the underflow and overflow thresholds.
        for (int i = 0; i < 600; i++) begin
            if (i % 2 == 0) t = $urandom_range(0, 4) - 2;
            else t = 253 + $urandom_range(0, 4);
            lo = (t + 127 - 254 > 1) ? t + 127 - 254 : 1;
            hi = (t + 126 < 254) ? t + 126 : 254;
            ea = $urandom_range(lo, hi);
            av = mk(ea);
            rv = mk(t + 127 - ea);
            issue(av, rv, ref_mul(av, rv));
        end

        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            av = rnd_any();
            rv = rnd_any();
            issue(av, rv, ref_mul(av, rv));
        end
        drain();

        // Reset during flight: two ops in the pipe, a third on the inputs.
        issue(32'h4040_0000, 32'h3F00_0000, 32'h3FC0_0000);
        issue(32'h40A0_0000, 32'h3E80_0000, 32'h3FA0_0000);
        @(negedge clk);
        fi.valid_in = 1'b1;
        fi.a = 32'h4000_0000;
        r_drv = 32'h3F80_0000;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        have_last = 1'b0;
        #1;
        chk("midreset_valid_out", {31'd0, fi.valid_out}, 32'd0);
        chk("midreset_q", fi.q, 32'd0);
        idle();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) idle();
        chk("post_reset_q", fi.q, 32'd0);
        issue(32'h4100_0000, 32'h3E00_0000, 32'h3F80_0000);
        drain();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
